// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
//   seq_state_t  : FSM encoding, also exported on the seq_state debug port
//   calc_cnt_w   : width of the counter shared by RELEASE and SOFT_ASSERT
//   calc_idx_w   : width of the release index (at least one bit)
package rst_seq_pkg;

  typedef enum logic [2:0] {
    RST         = 3'd0,
    SYNC_WAIT   = 3'd1,
    RELEASE     = 3'd2,
    DONE        = 3'd3,
    SOFT_ASSERT = 3'd4
  } seq_state_t;

  function automatic int unsigned calc_cnt_w(input int unsigned gap_cyc,
                                             input int unsigned soft_hold);
    int unsigned max_cyc;
    max_cyc = (gap_cyc > soft_hold) ? gap_cyc : soft_hold;
    return $clog2(max_cyc + 1);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned num_rst);
    return (num_rst > 1) ? $clog2(num_rst) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Bus between the reset sequencer and its clients.
//   soft_rst_req : level soft-reset request, held until soft_rst_ack
//   soft_rst_ack : one-cycle pulse when a soft-initiated sequence completes
//   rst_out_n    : per-block active-low resets, index 0 released first
//   rst_done     : all outputs released, sequencer idle
//   seq_state    : current FSM state (debug)
// master = sequencer side, slave = requester/consumer side.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_RST = 4
) ();

  logic               soft_rst_req;
  logic               soft_rst_ack;
  logic [NUM_RST-1:0] rst_out_n;
  logic               rst_done;
  logic [2:0]         seq_state;

  modport master (
    input  soft_rst_req,
    output soft_rst_ack,
    output rst_out_n,
    output rst_done,
    output seq_state
  );

  modport slave (
    output soft_rst_req,
    input  soft_rst_ack,
    input  rst_out_n,
    input  rst_done,
    input  seq_state
  );

endinterface

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer.
//   rtl_clk   : clock
//   rstb      : raw asynchronous active-low reset
//   rstb_sync : rstb with de-assertion delayed by STAGES flops
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic rtl_clk,
  input  logic rstb,
  output logic rstb_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge rtl_clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rstb_sync = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the rtl_clk domain.
// Releases NUM_RST downstream resets one at a time, GAP_CYC cycles apart, after the
// board reset has been synchronized. A soft reset (req/ack on the bus) drops all outputs
// for SOFT_HOLD cycles and replays the release sequence without the sync wait.
//   rtl_clk : clock, rising edge
//   rstb    : asynchronous active-low board reset
//   bus     : rst_seq_ctrl_if master (soft_rst_req/ack, rst_out_n, rst_done, seq_state)
// Every bus output is driven straight from a flop so downstream resets cannot glitch.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_RST     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned SOFT_HOLD   = 4
) (
  input  logic                  rtl_clk,
  input  logic                  rstb,
  rst_seq_ctrl_if.master        bus
);

  localparam int unsigned CNT_W = calc_cnt_w(GAP_CYC, SOFT_HOLD);
  localparam int unsigned IDX_W = calc_idx_w(NUM_RST);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);

  logic rstb_sync;

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] out_q, out_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;
  // Registered soft-reset acceptance; the FSM acts on it one edge later.
  logic               accept_q, accept_d;
  // Set once a soft reset has been taken; qualifies ack at the end of the sequence.
  logic               soft_q, soft_d;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .rtl_clk   (rtl_clk),
    .rstb      (rstb),
    .rstb_sync (rstb_sync)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    out_d    = out_q;
    soft_d   = soft_q;
    accept_d = 1'b0;

    unique case (state_q)
      RST: begin
        state_d = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (rstb_sync) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d        = '0;
          out_d[idx_q] = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (accept_q) begin
          state_d = SOFT_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = '0;
          soft_d  = 1'b1;
        end else begin
          // done_q keeps a request held through the final release from being taken
          // on the very edge ack rises; ack_q masks the cycle after.
          accept_d = done_q && bus.soft_rst_req && !ack_q;
        end
      end
      SOFT_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RST;
      end
    endcase

    done_d = (state_q == DONE) && !accept_q;
    ack_d  = done_d && !done_q && soft_q;
  end

  always_ff @(posedge rtl_clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= RST;
      cnt_q    <= '0;
      idx_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      accept_q <= 1'b0;
      soft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      accept_q <= accept_d;
      soft_q   <= soft_d;
    end
  end

  assign bus.rst_out_n    = out_q;
  assign bus.rst_done     = done_q;
  assign bus.soft_rst_ack = ack_q;
  assign bus.seq_state    = state_q;

endmodule
